// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
//   - state_e      : FSM state encoding (visible on state_o for debug)
//   - OP_*         : primary opcodes (instruction[31:26]) that are supported
//   - ALU_*        : alu_op encodings
//   - SRCB_*       : alu_src_b mux encodings
//   - PCSRC_*      : pc_source mux encodings
//   - is_wait_state: states that wait on the memory ready handshake
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_FAULT     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles that memory has not answered while the sequencer
// sits in a memory-wait state, and flags a timeout on the cycle where the
// count has reached MAX_WAIT and memory is still not ready.
//   clk, rst     : clock, synchronous active-high reset
//   active_i     : sequencer is in a state that waits on mem_ready
//   mem_ready_i  : memory handshake
//   timeout_o    : combinational; next state must be the fault state
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count only survives while staying in the same wait state with
  // mem_ready low; every exit (ready, timeout, or leaving the wait state)
  // goes through the clear, which covers the clear-on-state-change rule.
  assign timeout_o = active_i && !mem_ready_i && (cnt_q == CW'(MAX_WAIT));

  always_comb begin
    cnt_d = '0;
    if (active_i && !mem_ready_i && !timeout_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer. Steps each instruction through
// fetch / decode / execute / memory / write-back and drives the datapath
// strobes and mux selects.
// Handshake: in FETCH, MEM_RD and MEM_WR the current request is held until a
// cycle with mem_ready=1, which completes it and lets the FSM advance;
// mem_ready is ignored in every other state.
//   clk, rst          : clock, synchronous active-high reset
//   opcode            : instruction[31:26] from the IR
//   mem_ready         : memory completed the current access this cycle
//   pc_write .. pc_source : datapath strobes and selects
//   state_o           : current state (debug)
//   illegal_op        : one-cycle pulse in DECODE for unsupported opcodes
//   mem_fault         : sticky memory-timeout flag
//   instr_count       : retired instruction counter (wraps)
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_o,
  output logic             illegal_op,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic             timeout;
  logic             retire;
  logic             mem_fault_q;
  logic [CNT_W-1:0] instr_cnt_q;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .active_i   (is_wait_state(state_q)),
    .mem_ready_i(mem_ready),
    .timeout_o  (timeout)
  );

  // State register plus the status registers that update with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      mem_fault_q <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (timeout) mem_fault_q <= 1'b1;
      if (retire)  instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (timeout)        state_d = S_FAULT;
        else if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (timeout)        state_d = S_FAULT;
        else if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR: begin
        if (timeout)        state_d = S_FAULT;
        else if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode. Everything is held low during reset so an aborted
  // instruction never issues a strobe in the reset cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    retire        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          // Mealy: load IR and advance PC only on the completing cycle.
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
            default:                                       illegal_op = 1'b1;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = mem_ready;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          retire        = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
          retire    = 1'b1;
        end
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o     = state_q;
  assign mem_fault   = mem_fault_q;
  assign instr_count = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each instruction is expanded into the list
// of cycles it must take (fetch waits, decode, execute/memory phases), and
// every cycle is checked for state and the full control bundle.
module tb_multicycle_control;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 32;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_fault;
  } ctrl_t;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       opcode = '0;
  logic             mem_ready = 1'b0;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state_o;
  logic             illegal_op, mem_fault;
  logic [CNT_W-1:0] instr_count;

  always #5 clk = ~clk;

  multicycle_control #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_o(state_o), .illegal_op(illegal_op),
    .mem_fault(mem_fault), .instr_count(instr_count)
  );

  ctrl_t      obs;
  logic [6:0] strobes;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op, mem_fault};
  assign strobes = {pc_write, pc_write_cond, mem_read, mem_write, ir_write,
                    reg_write, illegal_op};

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B ||
           op == 6'h04 || op == 6'h02 || op == 6'h08;
  endfunction

  // Control bundle each state must show, straight from the state table.
  function automatic ctrl_t exp_ctrl(input int st, input bit rdy, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  begin c.alu_src_b = 2'b11; c.illegal_op = !is_legal(op); end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.i_or_d = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.i_or_d = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: begin c.reg_write = 1; end
      15: begin c.mem_fault = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle: drive inputs on the falling edge, check just after.
  task automatic step(input bit rdy, input logic [5:0] op, input int st);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    #1;
    chk($sformatf("state@%0d", st), 32'(state_o), 32'(st));
    chk($sformatf("ctrl@%0d", st), 32'(obs), 32'(exp_ctrl(st, rdy, op)));
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'($urandom);
      opcode    = 6'($urandom);
      #1;
      chk({tag, "_strobes"}, 32'(strobes), 32'd0);
    end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_cnt = '0;
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_fault"}, 32'(mem_fault), 32'd0);
    chk({tag, "_count"}, instr_count, exp_cnt);
  endtask

  // Expand one instruction into its expected cycle trace.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    chk("count_pre", instr_count, exp_cnt);
    repeat (fw) step(1'b0, 6'($urandom), 0);
    step(1'b1, 6'($urandom), 0);
    step(1'($urandom), op, 1);
    case (op)
      6'h23: begin
        step(1'($urandom), op, 2);
        repeat (mw) step(1'b0, op, 3);
        step(1'b1, op, 3);
        step(1'($urandom), op, 4);
        exp_q.push_back(exp_cnt + 1);
      end
      6'h2B: begin
        step(1'($urandom), op, 2);
        repeat (mw) step(1'b0, op, 5);
        step(1'b1, op, 5);
        exp_q.push_back(exp_cnt + 1);
      end
      6'h00: begin step(1'($urandom), op, 6); step(1'($urandom), op, 7); exp_q.push_back(exp_cnt + 1); end
      6'h04: begin step(1'($urandom), op, 8); exp_q.push_back(exp_cnt + 1); end
      6'h02: begin step(1'($urandom), op, 9); exp_q.push_back(exp_cnt + 1); end
      6'h08: begin step(1'($urandom), op, 10); step(1'($urandom), op, 11); exp_q.push_back(exp_cnt + 1); end
      default: exp_q.push_back(exp_cnt);
    endcase
    exp_cnt = exp_q.pop_front();
    @(posedge clk);
    #1;
    chk("count_post", instr_count, exp_cnt);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset");

    // Directed: R-type, lw with waits, then sw/beq/j/addi back to back.
    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 3, 2);
    run_instr(6'h2B, 0, 0);
    run_instr(6'h04, 0, 0);
    run_instr(6'h02, 0, 0);
    run_instr(6'h08, 0, 0);
    run_instr(6'h3F, 0, 0);
    // Longest legal waits: MAX_WAIT low cycles must not fault.
    run_instr(6'h23, MAX_WAIT, MAX_WAIT);
    run_instr(6'h2B, MAX_WAIT, MAX_WAIT);

    // Random instruction mix.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int fw, mw;
      if ($urandom_range(0, 6) == 6) op = 6'($urandom);
      else                           op = legal_ops[$urandom_range(0, 5)];
      fw = ($urandom_range(0, 9) == 0) ? MAX_WAIT : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? MAX_WAIT : $urandom_range(0, 3);
      run_instr(op, fw, mw);
    end

    // Timeout in MEM_RD: MAX_WAIT+1 low cycles lead to FAULT, which sticks.
    step(1'b1, 6'($urandom), 0);
    step(1'b0, 6'h23, 1);
    step(1'b0, 6'h23, 2);
    repeat (MAX_WAIT + 1) step(1'b0, 6'h23, 3);
    repeat (6) step(1'($urandom), 6'($urandom), 15);
    do_reset("fault_reset");
    run_instr(6'h04, 1, 0);

    // Reset in the middle of a store: no mem_write in the reset cycle.
    step(1'b1, 6'($urandom), 0);
    step(1'b0, 6'h2B, 1);
    step(1'b0, 6'h2B, 2);
    step(1'b0, 6'h2B, 5);
    do_reset("wr_reset");
    run_instr(6'h08, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
